// File: rtl/reg_bank.sv
// General-purpose register bank: one write port, two registered read ports, per-register busy scoreboard.
// Latency: reads return 1 cycle after the request; writes are visible to reads from the next cycle on.
// Backpressure: none, every enabled request is accepted. `define REG_BANK_BYPASS_EN forwards same-cycle writes to reads.
module reg_bank #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chip_enable,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      select1,
    input  logic [ADDR_W-1:0]      select2,
    output logic [WIDTH-1:0]       source1,
    output logic [WIDTH-1:0]       source2,
    output logic                   rd_valid,
    output logic                   busy1,
    output logic                   busy2,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      dest,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       dataIn,
    output logic [(2**ADDR_W)-1:0] busy_vec
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [WIDTH-1:0] rd1_dat, rd2_dat;
    logic             rd1_busy, rd2_busy;
    logic             wr_blocked, iss_blocked;

    assign busy_vec    = busy;
    assign wr_blocked  = (ZERO_REG != 0) && (wr_addr == '0);
    assign iss_blocked = (ZERO_REG != 0) && (dest == '0);

    always_comb begin
        rd1_dat  = mem[select1];
        rd1_busy = busy[select1];
        rd2_dat  = mem[select2];
        rd2_busy = busy[select2];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && (select1 == wr_addr)) begin
            rd1_dat  = dataIn;
            rd1_busy = 1'b0;
        end
        if (wr_en && (select2 == wr_addr)) begin
            rd2_dat  = dataIn;
            rd2_busy = 1'b0;
        end
`endif
        // The hardwired zero register overrides any forwarded value.
        if ((ZERO_REG != 0) && (select1 == '0)) begin
            rd1_dat  = '0;
            rd1_busy = 1'b0;
        end
        if ((ZERO_REG != 0) && (select2 == '0)) begin
            rd2_dat  = '0;
            rd2_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem      <= '{default: '0};
            busy     <= '0;
            source1  <= '0;
            source2  <= '0;
            busy1    <= 1'b0;
            busy2    <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (chip_enable) begin
                if (rd_en) begin
                    source1  <= rd1_dat;
                    source2  <= rd2_dat;
                    busy1    <= rd1_busy;
                    busy2    <= rd2_busy;
                    rd_valid <= 1'b1;
                end
                if (wr_en && !wr_blocked) begin
                    mem[wr_addr]  <= dataIn;
                    busy[wr_addr] <= 1'b0;
                end
                // Later assignment wins: a same-cycle issue keeps the register busy.
                if (issue_en && !iss_blocked) begin
                    busy[dest] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: two instances (ZERO_REG=0 and ZERO_REG=1) share stimulus; a queue-based scoreboard checks every cycle.
module tb_reg_bank;
    typedef struct packed {
        logic        rv;
        logic [15:0] s1;
        logic [15:0] s2;
        logic        b1;
        logic        b2;
        logic [7:0]  bv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, chip_enable, rd_en, issue_en, wr_en;
    logic [2:0]  select1, select2, dest, wr_addr;
    logic [15:0] dataIn;

    logic [1:0][15:0] s1, s2;
    logic [1:0][7:0]  bv;
    logic [1:0]       rv, b1, b2;

    int vectors = 0;
    int miscompares = 0;

    // Reference state, index 0 = ZERO_REG off, index 1 = ZERO_REG on.
    logic [15:0] m_mem [2][8];
    logic [7:0]  m_busy [2];
    exp_t        m_out [2];
    exp_t        q0[$];
    exp_t        q1[$];

    reg_bank #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .chip_enable(chip_enable), .rd_en(rd_en),
        .select1(select1), .select2(select2), .source1(s1[0]), .source2(s2[0]),
        .rd_valid(rv[0]), .busy1(b1[0]), .busy2(b2[0]), .issue_en(issue_en),
        .dest(dest), .wr_en(wr_en), .wr_addr(wr_addr), .dataIn(dataIn), .busy_vec(bv[0])
    );

    reg_bank #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .chip_enable(chip_enable), .rd_en(rd_en),
        .select1(select1), .select2(select2), .source1(s1[1]), .source2(s2[1]),
        .rd_valid(rv[1]), .busy1(b1[1]), .busy2(b2[1]), .issue_en(issue_en),
        .dest(dest), .wr_en(wr_en), .wr_addr(wr_addr), .dataIn(dataIn), .busy_vec(bv[1])
    );

    function automatic void model_read(input int k, input logic [2:0] a,
                                       output logic [15:0] d, output logic b);
        d = m_mem[k][a];
        b = m_busy[k][a];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && a == wr_addr) begin
            d = dataIn;
            b = 1'b0;
        end
`endif
        if (k == 1 && a == 3'd0) begin
            d = 16'h0;
            b = 1'b0;
        end
    endfunction

    task automatic step(input logic r, input logic ce, input logic rd,
                        input logic [2:0] a1, input logic [2:0] a2,
                        input logic iss, input logic [2:0] d,
                        input logic wr, input logic [2:0] wa, input logic [15:0] din);
        @(negedge clk);
        reset = r; chip_enable = ce; rd_en = rd; select1 = a1; select2 = a2;
        issue_en = iss; dest = d; wr_en = wr; wr_addr = wa; dataIn = din;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0;
                m_busy[k] = 8'h0;
                m_out[k]  = '0;
            end else begin
                m_out[k].rv = 1'b0;
                if (ce) begin
                    if (rd) begin
                        model_read(k, a1, m_out[k].s1, m_out[k].b1);
                        model_read(k, a2, m_out[k].s2, m_out[k].b2);
                        m_out[k].rv = 1'b1;
                    end
                    if (wr && !(k == 1 && wa == 3'd0)) begin
                        m_mem[k][wa]  = din;
                        m_busy[k][wa] = 1'b0;
                    end
                    if (iss && !(k == 1 && d == 3'd0)) m_busy[k][d] = 1'b1;
                end
            end
            m_out[k].bv = m_busy[k];
            if (k == 0) q0.push_back(m_out[k]);
            else        q1.push_back(m_out[k]);
        end
    endtask

    // Monitor: after every active edge, pop the expected output state of each instance and compare.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0)) begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    a = {rv[k], s1[k], s2[k], b1[k], b2[k], bv[k]};
                    vectors++;
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL outputs zr=%0d t=%0t: got rv=%b s1=%h s2=%h b1=%b b2=%b bv=%h, want rv=%b s1=%h s2=%h b1=%b b2=%b bv=%h",
                                 k, $time, a.rv, a.s1, a.s2, a.b1, a.b2, a.bv,
                                 e.rv, e.s1, e.s2, e.b1, e.b2, e.bv);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; chip_enable = 1'b0; rd_en = 1'b0; select1 = '0; select2 = '0;
        issue_en = 1'b0; dest = '0; wr_en = 1'b0; wr_addr = '0; dataIn = '0;
        //     r  ce rd a1 a2 iss d  wr wa din
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        step(1, 1, 1, 3, 4, 1, 1, 1, 2, 16'h1111);  // reset overrides everything
        step(0, 1, 1, 0, 7, 0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 3, 16'hBEEF);
        step(0, 1, 1, 3, 3, 0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 5, 16'h00AA);
        step(0, 1, 1, 1, 5, 0, 0, 1, 5, 16'h1234);  // same-cycle read/write
        step(0, 1, 1, 5, 5, 0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 1, 2, 0, 0, 16'h0);
        step(0, 1, 1, 2, 3, 0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 2, 16'h0055);
        step(0, 1, 0, 0, 0, 1, 2, 1, 2, 16'h0077);  // issue beats write on busy
        step(0, 1, 1, 2, 2, 0, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0, 16'hFFFF);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 3, 5, 1, 6, 1, 6, 16'hDEAD);  // chip disabled
        step(0, 1, 1, 6, 3, 0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        step(1, 1, 1, 6, 3, 0, 0, 0, 0, 16'h0);
        step(0, 1, 1, 3, 6, 0, 0, 0, 0, 16'h0);
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) != 0), 1'($urandom),
                 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), 3'($urandom), 16'($urandom));
        end
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (q0.size() + q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q0.size() + q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
